// File: rtl/cpu_pkg.sv
// Shared CPU types: data width, register address width and the writeback
// request payload used by both the pipeline and long-latency paths.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wd;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO of writeback requests with a combinational
// destination-register lookup over the live entries.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  wb_req_t               push_data,
    input  logic                  pop,
    output wb_req_t               head,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] count,
    input  logic [REG_ADDR_W-1:0] match_addr1,
    input  logic [REG_ADDR_W-1:0] match_addr2,
    output logic                  match1,
    output logic                  match2
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [DEPTH-1:0] live;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; count/pointers alone decide which entries
    // are live, so stale data is never observed and the array maps to RAM.
    always_ff @(posedge clk) begin
        if (push) mem[tail_ptr] <= push_data;
    end

    assign head  = mem[head_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // NOTE: every always_comb output gets a default before any conditional
    // update, so no path can hold a previous value and infer a latch.
    always_comb begin
        live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = ({1'b0, PTR_W'(i) - head_ptr} < count);
        end
    end

    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (mem[i].rd == match_addr1)) match1 = 1'b1;
            if (live[i] && (mem[i].rd == match_addr2)) match2 = 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback first, buffered
// long-latency results second, zero-latency bypass when idle.
module wb_arbiter #(
    parameter int XLEN       = cpu_pkg::XLEN,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pipe_we,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]                pipe_wd,
    input  logic                           ll_valid,
    output logic                           ll_ready,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] ll_rd,
    input  logic [XLEN-1:0]                ll_wd,
    output logic                           pipe_stall,
    output logic                           regwrite,
    output logic [cpu_pkg::REG_ADDR_W-1:0] waddr,
    output logic [XLEN-1:0]                wdata,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] chk_raddr1,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] chk_raddr2,
    output logic                           chk_busy1,
    output logic                           chk_busy2
);

    import cpu_pkg::*;

    localparam int                PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W + 1)'(DEPTH);
    localparam int                CNT_W     = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

    wb_req_t          ll_req;
    wb_req_t          fifo_head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PTR_W:0]   fifo_count;
    logic             match1;
    logic             match2;

    logic             pipe_eff;
    logic             ll_eff;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_next;
    logic             stall_next;

    assign ll_req   = '{rd: ll_rd, wd: ll_wd};
    assign ll_ready = !reset && !fifo_full;
    assign pipe_eff = pipe_we && (pipe_rd != '0);
    assign ll_eff   = ll_valid && ll_ready && (ll_rd != '0);

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_data  (ll_req),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .match_addr1(chk_raddr1),
        .match_addr2(chk_raddr2),
        .match1     (match1),
        .match2     (match2)
    );

    // A bypassed LL result is consumed by the write port and never enqueued.
    always_comb begin
        regwrite  = 1'b0;
        waddr     = '0;
        wdata     = '0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (!reset) begin
            if (pipe_eff) begin
                regwrite  = 1'b1;
                waddr     = pipe_rd;
                wdata     = pipe_wd;
                fifo_push = ll_eff;
            end else if (!fifo_empty) begin
                regwrite  = 1'b1;
                waddr     = fifo_head.rd;
                wdata     = fifo_head.wd;
                fifo_pop  = 1'b1;
                fifo_push = ll_eff;
            end else if (ll_eff) begin
                regwrite  = 1'b1;
                waddr     = ll_rd;
                wdata     = ll_wd;
            end
        end
    end

    // Counts consecutive cycles a buffered result is locked out by the pipe.
    always_comb begin
        starve_next = starve_cnt;
        stall_next  = pipe_stall;
        if (fifo_empty || fifo_pop) begin
            starve_next = '0;
        end else if (pipe_eff && (starve_cnt != STARVE_LIM)) begin
            starve_next = starve_cnt + 1'b1;
        end
        if (fifo_pop) begin
            stall_next = 1'b0;
        end else if (starve_next == STARVE_LIM) begin
            stall_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else begin
            starve_cnt <= starve_next;
            pipe_stall <= stall_next;
        end
    end

    assign chk_busy1 = !reset && (chk_raddr1 != '0) && match1;
    assign chk_busy2 = !reset && (chk_raddr2 != '0) && match2;

    a_no_write_while_stalled: assert property (
        @(posedge clk) disable iff (reset) !(pipe_we && pipe_stall));

    a_count_in_range: assert property (
        @(posedge clk) disable iff (reset) (fifo_count <= DEPTH_CNT));

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts each
// register-file write; a monitor pops and compares whenever regwrite is seen.
module tb_wb_arbiter;

    localparam int XLEN       = 32;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] wd;
    } wr_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            pipe_we = 1'b0;
    logic [4:0]      pipe_rd = '0;
    logic [XLEN-1:0] pipe_wd = '0;
    logic            ll_valid = 1'b0;
    logic            ll_ready;
    logic [4:0]      ll_rd = '0;
    logic [XLEN-1:0] ll_wd = '0;
    logic            pipe_stall;
    logic            regwrite;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic [4:0]      chk_raddr1 = '0;
    logic [4:0]      chk_raddr2 = '0;
    logic            chk_busy1;
    logic            chk_busy2;

    always #5 clk = ~clk;

    wb_arbiter #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pipe_we   (pipe_we),
        .pipe_rd   (pipe_rd),
        .pipe_wd   (pipe_wd),
        .ll_valid  (ll_valid),
        .ll_ready  (ll_ready),
        .ll_rd     (ll_rd),
        .ll_wd     (ll_wd),
        .pipe_stall(pipe_stall),
        .regwrite  (regwrite),
        .waddr     (waddr),
        .wdata     (wdata),
        .chk_raddr1(chk_raddr1),
        .chk_raddr2(chk_raddr2),
        .chk_busy1 (chk_busy1),
        .chk_busy2 (chk_busy2)
    );

    wr_t exp_q[$];
    wr_t model_q[$];
    int  total = 0;
    int  bad = 0;
    bit  model_stall = 1'b0;
    int  blocked_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive inputs, predict the cycle from the model, check
    // handshake/status outputs mid-cycle, then advance the model past the edge.
    task automatic step(input bit rst, input bit pw, input logic [4:0] prd, input logic [XLEN-1:0] pwd,
                        input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] lwd,
                        input logic [4:0] c1, input logic [4:0] c2, output bit accepted);
        bit ready_e, pipe_e, ll_e, busy1_e, busy2_e, popped, had_entries;
        @(posedge clk);
        #1;
        if (model_stall) pw = 1'b0;
        reset = rst; pipe_we = pw; pipe_rd = prd; pipe_wd = pwd;
        ll_valid = lv; ll_rd = lrd; ll_wd = lwd;
        chk_raddr1 = c1; chk_raddr2 = c2;

        ready_e     = !rst && (model_q.size() < DEPTH);
        accepted    = lv && ready_e;
        pipe_e      = pw && (prd != 0);
        ll_e        = accepted && (lrd != 0);
        had_entries = (model_q.size() > 0);
        busy1_e     = 1'b0;
        busy2_e     = 1'b0;
        if (!rst) begin
            foreach (model_q[i]) begin
                if (c1 != 0 && model_q[i].rd == c1) busy1_e = 1'b1;
                if (c2 != 0 && model_q[i].rd == c2) busy2_e = 1'b1;
            end
        end

        popped = 1'b0;
        if (!rst) begin
            if (pipe_e) begin
                exp_q.push_back('{rd: prd, wd: pwd});
                if (ll_e) model_q.push_back('{rd: lrd, wd: lwd});
            end else if (had_entries) begin
                exp_q.push_back(model_q.pop_front());
                popped = 1'b1;
                if (ll_e) model_q.push_back('{rd: lrd, wd: lwd});
            end else if (ll_e) begin
                exp_q.push_back('{rd: lrd, wd: lwd});
            end
        end

        @(negedge clk);
        check("ll_ready", ll_ready, ready_e);
        check("pipe_stall", pipe_stall, model_stall);
        check("chk_busy1", chk_busy1, busy1_e);
        check("chk_busy2", chk_busy2, busy2_e);

        if (rst) begin
            model_q.delete();
            model_stall = 1'b0;
            blocked_run = 0;
        end else begin
            if (popped) begin
                model_stall = 1'b0;
                blocked_run = 0;
            end else if (!had_entries) begin
                blocked_run = 0;
            end else if (pipe_e) begin
                blocked_run++;
            end
            if (!popped && blocked_run >= STARVE_MAX) model_stall = 1'b1;
        end
    endtask

    // Monitor: every presented write must be the next predicted one.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (regwrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got x%0d=%0h, required no write (t=%0t)", waddr, wdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("waddr", waddr, e.rd);
                    check("wdata", wdata, e.wd);
                end
            end else begin
                check("idle_port", {waddr, wdata}, '0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        bit hold;
        bit lv;
        bit rst;
        logic [4:0] lrd;
        logic [XLEN-1:0] lwd;
        int first_stall;
        int tries;
        int pw_pct;

        repeat (2) @(posedge clk);

        // Reset state, then zero-latency bypass into an empty FIFO.
        step(1, 0, 0, 0, 0, 0, 0, 5, 0, acc);
        step(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0, acc);
        step(0, 0, 0, 0, 0, 0, 0, 5, 0, acc);

        // Pipe wins; LL result is buffered, visible as busy, written next cycle.
        step(0, 1, 3, 32'h11, 1, 7, 32'h22, 7, 3, acc);
        step(0, 0, 0, 0, 0, 0, 0, 7, 0, acc);
        step(0, 0, 0, 0, 0, 0, 0, 7, 0, acc);

        // Fill the FIFO behind a busy pipe, hold off a fifth result, then drain.
        for (int k = 0; k < DEPTH; k++) begin
            step(0, 1, 1, 32'h100 + k, 1, 5'(10 + k), 32'hA0 + k, 5'(10 + k), 13, acc);
        end
        step(0, 1, 1, 32'h200, 1, 14, 32'hE0, 10, 14, acc);
        step(0, 1, 1, 32'h201, 1, 14, 32'hE0, 11, 14, acc);
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 8) begin
            step(0, 0, 0, 0, 1, 14, 32'hE0, 12, 14, acc);
            tries++;
        end
        check("fifth_ll_accepted_within_budget", tries < 8, 1);
        repeat (DEPTH + 1) step(0, 0, 0, 0, 0, 0, 0, 13, 14, acc);

        // Starvation: one buffered entry, pipe held high until the stall request.
        step(0, 1, 2, 32'h55, 1, 9, 32'h99, 9, 0, acc);
        first_stall = -1;
        for (int j = 1; j <= STARVE_MAX + 4; j++) begin
            step(0, 1, 2, 32'h55 + j, 0, 0, 0, 9, 0, acc);
            if (pipe_stall === 1'b1 && first_stall < 0) first_stall = j;
        end
        check("first_stall_cycle", first_stall, STARVE_MAX + 1);

        // Writes to x0 are discarded on both paths.
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 32'h1234 + k, 1, 0, 32'h5678 + k, 0, 0, acc);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);

        // Reset mid-drain throws away the buffered entries.
        step(0, 1, 4, 32'h40, 1, 20, 32'hC0, 0, 0, acc);
        step(0, 1, 4, 32'h41, 1, 21, 32'hC1, 0, 0, acc);
        step(0, 1, 4, 32'h42, 1, 22, 32'hC2, 21, 22, acc);
        step(0, 0, 0, 0, 0, 0, 0, 21, 22, acc);
        step(1, 0, 0, 0, 1, 23, 32'hC3, 21, 22, acc);
        step(0, 0, 0, 0, 0, 0, 0, 21, 22, acc);
        step(0, 0, 0, 0, 0, 0, 0, 22, 20, acc);

        // Randomised traffic with alternating light/heavy pipeline load.
        hold = 1'b0;
        lv   = 1'b0;
        lrd  = '0;
        lwd  = '0;
        for (int n = 0; n < 3000; n++) begin
            pw_pct = ((n / 150) % 2 == 1) ? 92 : 45;
            if (!hold) begin
                lv  = ($urandom_range(0, 99) < 55);
                lrd = 5'($urandom_range(0, 7));
                lwd = $urandom;
            end
            rst = ($urandom_range(0, 399) == 0);
            step(rst, ($urandom_range(0, 99) < pw_pct), 5'($urandom_range(0, 31)), $urandom,
                 lv, lrd, lwd, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
            hold = lv && !acc && !rst;
        end

        repeat (DEPTH + 2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        check("scoreboard_drained", exp_q.size(), 0);
        check("model_fifo_empty_status", ll_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
